// File: rtl/dcm_prog_ctrl_if.sv
// dcm_prog_ctrl_if: request handshake plus DCM program/status signals of the reprogramming controller
interface dcm_prog_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_m_m1;
  logic [7:0] cfg_d_m1;
  logic       prog_en;
  logic       prog_data;
  logic       prog_done;
  logic       locked;
  logic       busy;
  logic       done;
  logic       err;
  modport master (
    output cfg_valid, cfg_m_m1, cfg_d_m1, prog_done, locked,
    input  cfg_ready, prog_en, prog_data, busy, done, err
  );
  modport slave (
    input  cfg_valid, cfg_m_m1, cfg_d_m1, prog_done, locked,
    output cfg_ready, prog_en, prog_data, busy, done, err
  );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl: serial DCM_CLKGEN M/D reprogramming with PROGDONE/LOCKED completion and timeout
module dcm_prog_ctrl #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic            clk,
  input logic            rst,
  dcm_prog_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE, WAIT_LOCK} state_t;
  localparam logic [3:0]  GAP = 4'(GAP_CYCLES);
  localparam logic [15:0] TO  = 16'(TIMEOUT_CYCLES);
  state_t      r_state;
  logic [7:0]  r_m, r_d;
  logic [3:0]  r_cnt;
  logic [15:0] r_tcnt;
  logic        r_lk1, r_lk2, r_ready, r_busy, r_en, r_data, r_done, r_err;
  logic [9:0]  w_seq;
  logic [15:0] w_tnext;
  logic        w_to;
  // Serial word: bit0 = 1, bit1 = 0 for D / 1 for M, then the 8-bit field LSB first
  always_comb begin
    w_seq   = r_state == LOAD_M ? {r_m, 2'b11} : {r_d, 2'b01};
    w_tnext = r_tcnt == TO ? r_tcnt : r_tcnt + 16'd1;
    w_to    = w_tnext == TO;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_data  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_lk1   <= 1'b0;
      r_lk2   <= 1'b0;
      r_cnt   <= 4'd0;
      r_tcnt  <= 16'd0;
      r_m     <= 8'd0;
      r_d     <= 8'd0;
    end else begin
      r_lk1  <= bus.locked;
      r_lk2  <= r_lk1;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && bus.cfg_valid) begin
            r_ready <= 1'b0;
            if (bus.cfg_m_m1 == 8'd0) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_m     <= bus.cfg_m_m1;
              r_d     <= bus.cfg_d_m1;
              r_state <= LOAD_D;
              r_busy  <= 1'b1;
              r_en    <= 1'b1;
              r_data  <= 1'b1;
              r_cnt   <= 4'd1;
            end
          end
        end
        LOAD_D, LOAD_M: begin
          if (r_cnt == 4'd10) begin
            r_state <= r_state == LOAD_D ? GAP_D : GAP_M;
            r_en    <= 1'b0;
            r_data  <= 1'b0;
            r_cnt   <= 4'd1;
          end else begin
            r_data <= w_seq[r_cnt];
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        GAP_D, GAP_M: begin
          if (r_cnt == GAP) begin
            r_state <= r_state == GAP_D ? LOAD_M : GO;
            r_en    <= 1'b1;
            r_data  <= r_state == GAP_D;
            r_cnt   <= 4'd1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        GO: begin
          r_state <= WAIT_DONE;
          r_en    <= 1'b0;
          r_data  <= 1'b0;
          r_tcnt  <= 16'd0;
        end
        default: begin
          r_tcnt <= w_tnext;
          // Timeout wins over a PROGDONE/LOCKED arriving on the same edge
          if (w_to || (r_state == WAIT_LOCK && r_lk2)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_err   <= w_to;
          end else if (r_state == WAIT_DONE && bus.prog_done) begin
            r_state <= WAIT_LOCK;
          end
        end
      endcase
    end
  end
  assign bus.cfg_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.prog_en   = r_en;
  assign bus.prog_data = r_data;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// tb_dcm_prog_ctrl: two instances (gap 2 and gap 1) against a queue-based model plus directed literal checks
module tb_dcm_prog_ctrl;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic [7:0] mv = 8'd0, dv = 8'd0;
  logic pd = 1'b0, lk = 1'b0;
  int n_pass = 0, n_tot = 0, cyc = 0;
  dcm_prog_ctrl_if if0 ();
  dcm_prog_ctrl_if if1 ();
  assign if0.cfg_valid = valid;
  assign if0.cfg_m_m1  = mv;
  assign if0.cfg_d_m1  = dv;
  assign if0.prog_done = pd;
  assign if0.locked    = lk;
  assign if1.cfg_valid = valid;
  assign if1.cfg_m_m1  = mv;
  assign if1.cfg_d_m1  = dv;
  assign if1.prog_done = pd;
  assign if1.locked    = lk;
  dcm_prog_ctrl #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(TO)) u0 (.clk(clk), .rst(rst), .bus(if0));
  dcm_prog_ctrl #(.GAP_CYCLES(1), .TIMEOUT_CYCLES(TO)) u1 (.clk(clk), .rst(rst), .bus(if1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // Behavioural model: program phase is a precomputed list of (en,data) per cycle
  logic e_rdy[2], e_busy[2], e_en[2], e_dat[2], e_done[2], e_err[2];
  int ph[2], wcnt[2], qn[2], qp[2];
  bit gotd[2], h1[2], h2[2];
  logic [1:0] seq[2][64];
  initial for (int i = 0; i < 2; i++) begin
    e_rdy[i] = 0; e_busy[i] = 0; e_en[i] = 0; e_dat[i] = 0; e_done[i] = 0; e_err[i] = 0;
    ph[i] = 0; wcnt[i] = 0; qn[i] = 0; qp[i] = 0; gotd[i] = 0; h1[i] = 0; h2[i] = 0;
  end
  task automatic push(input int i, input logic [1:0] v);
    seq[i][qn[i]] = v;
    qn[i]++;
  endtask
  task automatic model_step(input int i);
    int g;
    bit sync;
    g = (i == 0) ? 2 : 1;
    if (rst) begin
      e_rdy[i] = 0; e_busy[i] = 0; e_en[i] = 0; e_dat[i] = 0; e_done[i] = 0; e_err[i] = 0;
      ph[i] = 0; h1[i] = 0; h2[i] = 0;
    end else begin
      sync = h2[i];
      e_done[i] = 0;
      e_err[i] = 0;
      if (ph[i] == 0) begin
        if (e_rdy[i] && valid) begin
          e_rdy[i] = 0;
          if (mv == 8'd0) begin
            e_done[i] = 1;
            e_err[i] = 1;
          end else begin
            qn[i] = 0;
            qp[i] = 0;
            push(i, 2'b11); push(i, 2'b10);
            for (int b = 0; b < 8; b++) push(i, {1'b1, dv[b]});
            for (int b = 0; b < g; b++) push(i, 2'b00);
            push(i, 2'b11); push(i, 2'b11);
            for (int b = 0; b < 8; b++) push(i, {1'b1, mv[b]});
            for (int b = 0; b < g; b++) push(i, 2'b00);
            push(i, 2'b10);
            ph[i] = 1;
            e_busy[i] = 1;
            {e_en[i], e_dat[i]} = seq[i][0];
            qp[i] = 1;
          end
        end else e_rdy[i] = 1;
      end else if (ph[i] == 1) begin
        if (qp[i] < qn[i]) begin
          {e_en[i], e_dat[i]} = seq[i][qp[i]];
          qp[i]++;
        end else begin
          e_en[i] = 0; e_dat[i] = 0; ph[i] = 2; wcnt[i] = 0; gotd[i] = 0;
        end
      end else begin
        wcnt[i]++;
        if (wcnt[i] == TO || (gotd[i] && sync)) begin
          ph[i] = 0; e_busy[i] = 0; e_rdy[i] = 1; e_done[i] = 1; e_err[i] = (wcnt[i] == TO);
        end else if (!gotd[i] && pd) gotd[i] = 1;
      end
      h2[i] = h1[i];
      h1[i] = lk;
    end
  endtask
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    cyc++;
    #1;
    chk($sformatf("u0 outputs cyc %0d", cyc),
        32'({if0.cfg_ready, if0.busy, if0.prog_en, if0.prog_data, if0.done, if0.done & if0.err}),
        32'({e_rdy[0], e_busy[0], e_en[0], e_dat[0], e_done[0], e_done[0] & e_err[0]}));
    chk($sformatf("u1 outputs cyc %0d", cyc),
        32'({if1.cfg_ready, if1.busy, if1.prog_en, if1.prog_data, if1.done, if1.done & if1.err}),
        32'({e_rdy[1], e_busy[1], e_en[1], e_dat[1], e_done[1], e_done[1] & e_err[1]}));
  end
  // Directed runs: slot k is the cycle sampled at edge T+k after acceptance edge T
  logic [5:0] ob[2][200];
  bit sv[200], spd[200], slk[200], srst[200];
  task automatic clr();
    for (int k = 0; k < 200; k++) begin
      sv[k] = 0; spd[k] = 0; slk[k] = 0; srst[k] = 0;
    end
  endtask
  task automatic run(input logic [7:0] m, input logic [7:0] d, input int n);
    int w;
    w = 0;
    while (!(if0.cfg_ready && if1.cfg_ready) && w < 300) begin
      @(posedge clk);
      #2;
      w++;
    end
    chk("ready wait", 32'(w < 300), 32'd1);
    valid = 1'b1;
    mv = m;
    dv = d;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      #2;
      ob[0][k] = {if0.cfg_ready, if0.busy, if0.prog_en, if0.prog_data, if0.done, if0.err};
      ob[1][k] = {if1.cfg_ready, if1.busy, if1.prog_en, if1.prog_data, if1.done, if1.err};
      valid = sv[k]; pd = spd[k]; lk = slk[k]; rst = srst[k];
      @(posedge clk);
    end
    #2;
  endtask
  function automatic logic [31:0] seqv(input int u, input int a, input int b, input int p);
    logic [31:0] r;
    r = '0;
    for (int k = a; k <= b; k++) r = {r[30:0], ob[u][k][p]};
    return r;
  endfunction
  function automatic int first_k(input int u, input int a, input int b, input int p);
    for (int k = a; k <= b; k++) if (ob[u][k][p]) return k;
    return 0;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset outputs", 32'({if0.cfg_ready, if0.busy, if0.prog_en, if0.prog_data, if0.done, if0.err}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("ready after reset", 32'({if0.cfg_ready, if0.busy, if1.cfg_ready, if1.busy}), 32'b1010);
    clr();
    for (int k = 30; k < 200; k++) slk[k] = (k >= 40);
    spd[30] = 1;
    run(8'd31, 8'd63, 50);
    chk("D word bits", seqv(0, 1, 10, 2), 32'b1011111100);
    chk("M word bits", seqv(0, 13, 22, 2), 32'b1111111000);
    chk("prog_en frame", seqv(0, 1, 26, 3), 32'b11111111110011111111110010);
    chk("gap/GO data", seqv(0, 23, 26, 2), 32'b0000);
    chk("done slot u0", 32'(first_k(0, 1, 50, 1)), 32'd43);
    chk("done err u0", 32'(ob[0][43][0]), 32'd0);
    chk("gap1 GO frame", seqv(1, 21, 24, 3), 32'b1010);
    chk("done slot u1", 32'(first_k(1, 1, 50, 1)), 32'd43);
    clr();
    run(8'd0, 8'd5, 6);
    chk("reject pulse", 32'(ob[0][1]), 32'b000011);
    chk("reject ready back", 32'(ob[0][2]), 32'b100000);
    chk("reject no prog_en", seqv(0, 1, 6, 3) | seqv(1, 1, 6, 3), 32'd0);
    clr();
    spd[125] = 1;
    for (int k = 125; k < 200; k++) slk[k] = 1;
    run(8'd4, 8'd2, 130);
    chk("timeout slot u0", 32'(first_k(0, 1, 130, 1)), 32'd126);
    chk("timeout err u0", 32'(ob[0][126][0]), 32'd1);
    chk("timeout slot u1", 32'(first_k(1, 1, 130, 1)), 32'd124);
    clr();
    srst[15] = 1;
    run(8'd31, 8'd63, 40);
    chk("abort outputs", 32'({ob[0][16], ob[1][16]}), 32'd0);
    chk("abort no done", 32'(first_k(0, 16, 40, 1) + first_k(1, 16, 40, 1)), 32'd0);
    clr();
    spd[28] = 1;
    for (int k = 30; k < 200; k++) slk[k] = 1;
    run(8'd3, 8'd1, 40);
    chk("post-abort D bits", seqv(0, 1, 10, 2), 32'b1010000000);
    chk("post-abort M bits", seqv(0, 13, 22, 2), 32'b1111000000);
    chk("post-abort done", 32'(first_k(0, 1, 40, 1)), 32'd33);
    clr();
    for (int k = 0; k < 60; k++) sv[k] = (k < 40) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int k = 30; k < 200; k++) spd[k] = 1;
    for (int k = 35; k < 200; k++) slk[k] = 1;
    run(8'd31, 8'd63, 80);
    chk("b2b done cycle", 32'(ob[0][38]), 32'b100010);
    chk("b2b next LOAD_D", 32'(ob[0][39]), 32'b011100);
    chk("b2b second done", 32'(first_k(0, 39, 80, 1)), 32'd66);
    clr();
    spd[26] = 1;
    for (int k = 26; k < 200; k++) slk[k] = 1;
    run(8'd255, 8'd255, 40);
    chk("gap1 D all ones", seqv(1, 1, 10, 2), 32'b1011111111);
    chk("gap1 M all ones", seqv(1, 12, 21, 2), 32'b1111111111);
    chk("extreme done u0", 32'(first_k(0, 1, 40, 1)), 32'd29);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      rst   = ($urandom_range(0, 599) == 0);
      valid = 1'($urandom_range(0, 1));
      mv    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      dv    = 8'($urandom);
      pd    = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 14) == 0) lk = ~lk;
    end
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
